// File: rtl/search_pkg.sv
// Shared types and constants for the template-search sequencer.
// Image geometry, memory map and the sequencer state encoding.
package search_pkg;

    localparam int IMG_W       = 80;
    localparam int WIN         = 16;
    localparam int WPR         = 20;
    localparam int ADDR_W      = 12;
    localparam int FRAME_BASE  = 0;
    localparam int TPL_BASE    = 1600;
    localparam int TPL_WORDS   = 64;
    localparam int WIN_PER_ROW = 65;
    localparam int WIN_TOTAL   = 4225;
    localparam int CNT_W       = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TPL,
        S_START,
        S_SEARCH,
        S_FIN
    } state_t;

endpackage

// File: rtl/win_tagger.sv
// Window position/count tracker with end-of-pass count check.
// Ports: clk, rst_n, clear, step, check -> win_x, win_y, win_cnt, cnt_err.
module win_tagger
    import search_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic             check,
    output logic [6:0]       win_x,
    output logic [6:0]       win_y,
    output logic [CNT_W-1:0] win_cnt,
    output logic             cnt_err
);

    logic [CNT_W-1:0] cnt_nxt;

    // Next count includes a window arriving in the same cycle as check.
    always_comb begin
        cnt_nxt = win_cnt;
        if (step && (win_cnt != {CNT_W{1'b1}}))
            cnt_nxt = win_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_x   <= '0;
            win_y   <= '0;
            win_cnt <= '0;
            cnt_err <= 1'b0;
        end else if (clear) begin
            win_x   <= '0;
            win_y   <= '0;
            win_cnt <= '0;
            cnt_err <= 1'b0;
        end else begin
            if (step) begin
                if (win_x == 7'(IMG_W - WIN)) begin
                    win_x <= '0;
                    win_y <= win_y + 1'b1;
                end else begin
                    win_x <= win_x + 1'b1;
                end
            end
            win_cnt <= cnt_nxt;
            if (check)
                cnt_err <= (cnt_nxt != CNT_W'(WIN_TOTAL));
        end
    end

endmodule

// File: rtl/search_scheduler.sv
// Sequencer for one template-search pass: loader, then window handler.
// Ports: start/busy/done/cnt_err host side, tpl_* loader, wh_* handler, mem_addr, win_* tags.
module search_scheduler
    import search_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              cnt_err,
    output logic              tpl_en,
    input  logic [5:0]        tpl_idx,
    input  logic              tpl_done,
    output logic              wh_en,
    input  logic              wh_ack,
    input  logic [6:0]        wh_row,
    input  logic [6:0]        wh_col,
    input  logic              wh_ready,
    input  logic              wh_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              win_valid,
    output logic [6:0]        win_x,
    output logic [6:0]        win_y,
    output logic [CNT_W-1:0]  win_cnt
);

    state_t      state;
    logic        clear;
    logic        step;
    logic        check;
    logic [10:0] row_off;

    assign clear     = (state == S_IDLE) && start;
    assign step      = (state == S_SEARCH) && wh_ready;
    assign check     = (state == S_SEARCH) && wh_done;
    assign win_valid = step;

    // Row offset kept at 11 bits; out-of-range rows wrap, never clamp.
    assign row_off = 11'(wh_row) * 11'(WPR);

    // Port owner drives the address combinationally: no added latency.
    always_comb begin
        mem_addr = ADDR_W'(FRAME_BASE);
        unique case (state)
            S_TPL:
                mem_addr = ADDR_W'(TPL_BASE) + ADDR_W'(tpl_idx);
            S_SEARCH:
                mem_addr = ADDR_W'(FRAME_BASE) + ADDR_W'(row_off)
                         + ADDR_W'(wh_col);
            default:
                mem_addr = ADDR_W'(FRAME_BASE);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            tpl_en <= 1'b0;
            wh_en  <= 1'b0;
        end else begin
            tpl_en <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_TPL;
                        tpl_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                S_TPL: begin
                    if (tpl_done) begin
                        state <= S_START;
                        wh_en <= 1'b1;
                    end
                end
                S_START: begin
                    if (wh_ack) begin
                        state <= S_SEARCH;
                        wh_en <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (wh_done) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    win_tagger u_tagger (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .step    (step),
        .check   (check),
        .win_x   (win_x),
        .win_y   (win_y),
        .win_cnt (win_cnt),
        .cnt_err (cnt_err)
    );

endmodule

// File: tb/tb_search_scheduler.sv
// Scoreboard bench for search_scheduler: random window traffic vs. a
// positional model (n-th window sits at n%65, n/65).
module tb_search_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        cnt_err;
    logic        tpl_en;
    logic [5:0]  tpl_idx;
    logic        tpl_done;
    logic        wh_en;
    logic        wh_ack;
    logic [6:0]  wh_row;
    logic [6:0]  wh_col;
    logic        wh_ready;
    logic        wh_done;
    logic [11:0] mem_addr;
    logic        win_valid;
    logic [6:0]  win_x;
    logic [6:0]  win_y;
    logic [12:0] win_cnt;

    search_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cnt_err   (cnt_err),
        .tpl_en    (tpl_en),
        .tpl_idx   (tpl_idx),
        .tpl_done  (tpl_done),
        .wh_en     (wh_en),
        .wh_ack    (wh_ack),
        .wh_row    (wh_row),
        .wh_col    (wh_col),
        .wh_ready  (wh_ready),
        .wh_done   (wh_done),
        .mem_addr  (mem_addr),
        .win_valid (win_valid),
        .win_x     (win_x),
        .win_y     (win_y),
        .win_cnt   (win_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
    } tag_t;

    tag_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_win    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every presented tag must match the oldest expected one.
    tag_t mt;
    always @(negedge clk) begin
        if (rst_n && win_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_win_valid", 1, 0);
            end else begin
                mt = exp_q.pop_front();
                chk("tag_x", int'(win_x), mt.x);
                chk("tag_y", int'(win_y), mt.y);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass;
        n_win   = 0;
        start   = 1'b1;
        tpl_idx = 6'd5;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("tpl_en_pulse", int'(tpl_en), 1);
        chk("tpl_addr", int'(mem_addr), 1605);
        chk("busy_on_start", int'(busy), 1);
        chk("cnt_err_cleared", int'(cnt_err), 0);
        chk("win_cnt_cleared", int'(win_cnt), 0);
        tick();
        start = 1'b1;
        @(negedge clk);
        chk("tpl_en_single", int'(tpl_en), 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored_tpl_en", int'(tpl_en), 0);
        chk("start_ignored_busy", int'(busy), 1);
        tpl_done = 1'b1;
        tick();
        tpl_done = 1'b0;
        @(negedge clk);
        chk("wh_en_set", int'(wh_en), 1);
        tick();
        @(negedge clk);
        chk("wh_en_held", int'(wh_en), 1);
        wh_ack = 1'b1;
        tick();
        wh_ack = 1'b0;
        @(negedge clk);
        chk("wh_en_drop", int'(wh_en), 0);
        tick();
    endtask

    task automatic send_window(input bit with_done);
        tag_t t;
        if ($urandom_range(0, 3) == 0)
            tick();
        t.x = n_win % 65;
        t.y = n_win / 65;
        exp_q.push_back(t);
        n_win++;
        wh_ready = 1'b1;
        wh_done  = with_done;
        tick();
        wh_ready = 1'b0;
        wh_done  = 1'b0;
    endtask

    task automatic run_windows(input int n, input bit end_done);
        for (int i = 0; i < n; i++)
            send_window(end_done && (i == n - 1));
    endtask

    task automatic finish_pass;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_pulse", int'(seen), 1);
        chk("fin_cnt_err", int'(cnt_err), int'(n_win != 4225));
        chk("fin_win_cnt", int'(win_cnt), (n_win > 8191) ? 8191 : n_win);
        chk("fin_busy", int'(busy), 0);
        tick();
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        tick();
    endtask

    initial begin
        int r;
        int c;
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int c;
        rst_n    = 1'b0;
        start    = 1'b0;
        tpl_idx  = '0;
        tpl_done = 1'b0;
        wh_ack   = 1'b0;
        wh_row   = '0;
        wh_col   = '0;
        wh_ready = 1'b0;
        wh_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt_err", int'(cnt_err), 0);
        chk("rst_tpl_en", int'(tpl_en), 0);
        chk("rst_wh_en", int'(wh_en), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_win_cnt", int'(win_cnt), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        rst_n = 1'b1;
        tick();

        // wh_ready while idle is ignored
        wh_ready = 1'b1;
        @(negedge clk);
        chk("idle_win_valid", int'(win_valid), 0);
        tick();
        wh_ready = 1'b0;
        @(negedge clk);
        chk("idle_win_cnt", int'(win_cnt), 0);
        chk("idle_busy", int'(busy), 0);
        tick();

        // pass 1: full pass, count matches
        start_pass();
        wh_row = 7'd3;
        wh_col = 7'd7;
        @(negedge clk);
        chk("addr_3_7", int'(mem_addr), 67);
        wh_row = 7'd79;
        wh_col = 7'd19;
        @(negedge clk);
        chk("addr_79_19", int'(mem_addr), 1599);
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 127));
            c = int'($urandom_range(0, 127));
            wh_row = 7'(r);
            wh_col = 7'(c);
            @(negedge clk);
            chk("addr_rand", int'(mem_addr), (((r * 20) % 2048) + c) % 4096);
        end
        wh_row = '0;
        wh_col = '0;
        tick();
        run_windows(66, 1'b0);
        @(negedge clk);
        chk("win_cnt_66", int'(win_cnt), 66);
        chk("win_x_66", int'(win_x), n_win % 65);
        chk("win_y_66", int'(win_y), n_win / 65);
        tick();
        run_windows(4225 - 66, 1'b1);
        finish_pass();

        // pass 2: one window short
        start_pass();
        run_windows(4224, 1'b1);
        finish_pass();
        wh_ready = 1'b1;
        @(negedge clk);
        chk("post_idle_win_valid", int'(win_valid), 0);
        tick();
        wh_ready = 1'b0;
        @(negedge clk);
        chk("post_hold_win_cnt", int'(win_cnt), 4224);
        chk("post_hold_cnt_err", int'(cnt_err), 1);
        tick();

        // pass 3: reset in the middle of SEARCH
        start_pass();
        run_windows(100, 1'b0);
        @(negedge clk);
        chk("pre_rst_win_cnt", int'(win_cnt), 100);
        tick();
        wh_row = 7'd10;
        wh_col = 7'd3;
        rst_n  = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_win_cnt", int'(win_cnt), 0);
        chk("midrst_mem_addr", int'(mem_addr), 0);
        chk("midrst_wh_en", int'(wh_en), 0);
        rst_n = 1'b1;
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/search_scheduler.md
Name: search_scheduler

Overview:
Top-level sequencer for one template-search pass over an 80x80 8-bit image held in a single-read-port word memory (32-bit words).
- Grants the memory port first to the template loader, then to the window handler.
- Starts the window handler with an en/ack handshake and tags every window_ready pulse with its (x,y) position.
- Checks the window count at handler done and reports pass completion to the host.

Parameters:
IMG_W, 80, image width/height in pixels
WIN, 16, window edge in pixels
WPR, 20, 32-bit words per image row (IMG_W/4)
ADDR_W, 12, memory word-address width
FRAME_BASE, 0, word address of image pixel (0,0)
TPL_BASE, 1600, word address of first template word
TPL_WORDS, 64, template size in words (16x16/4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  host pulse: begin a pass
busy  out  1  high from accepted start until done
done  out  1  one-cycle pass-complete pulse
cnt_err  out  1  sticky: window count mismatch at last done; cleared by accepted start
tpl_en  out  1  template loader enable, one-cycle pulse
tpl_idx  in  6  template loader word index request
tpl_done  in  1  template loader finished, one-cycle pulse
wh_en  out  1  window handler enable
wh_ack  in  1  window handler accepted enable
wh_row  in  7  handler requested image row
wh_col  in  7  handler requested word column (0..19)
wh_ready  in  1  handler window_ready
wh_done  in  1  handler finished
mem_addr  out  ADDR_W  memory read word address (read data returns next cycle, unregistered by this block)
win_valid  out  1  window tag valid, equals wh_ready gated by SEARCH state
win_x  out  7  window left pixel, 0..64
win_y  out  7  window top pixel, 0..64
win_cnt  out  13  windows seen this pass

Behaviour:
- Reset values: state IDLE; busy, done, cnt_err, tpl_en, wh_en, win_valid = 0; win_x, win_y, win_cnt = 0; mem_addr = FRAME_BASE.
- States: IDLE, TPL, START, SEARCH, FIN.
- IDLE: start=1 -> TPL. Same cycle: tpl_en=1, busy=1, cnt_err cleared, win_x/win_y/win_cnt cleared.
- TPL: mem_addr = TPL_BASE + tpl_idx (combinational).
  - tpl_done=1 -> START.
  - start while busy is ignored in every state.
- START: wh_en=1 held until wh_ack=1 -> SEARCH. wh_en drops the cycle after ack is sampled.
- SEARCH: mem_addr = FRAME_BASE + wh_row*WPR + wh_col, combinational, zero added latency.
  - Out-of-range wh_row (>79) or wh_col (>19) is passed through unchanged; no clamping.
- Tagging, on each wh_ready=1 in SEARCH:
  - win_valid=1 that cycle, with the pre-increment win_x/win_y.
  - Then registered update: win_x = win_x+1. If win_x==IMG_W-WIN (64), win_x=0 and win_y=win_y+1.
  - win_cnt increments and saturates at 8191.
- wh_done=1 in SEARCH -> FIN.
  - If wh_ready arrives in the same cycle, that window is counted first.
  - cnt_err = (final win_cnt != 65*65 = 4225).
- FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
  - win_cnt, win_x, win_y and cnt_err hold until the next accepted start.
- wh_ready outside SEARCH is ignored: no count, win_valid=0.
- Arithmetic: wh_row*WPR is done at 11 bits, then sum truncated to ADDR_W.
- Reset mid-operation: immediate return to reset values. The handler and loader are reset by the same rst_n.

Decomposition:
- Shared package search_pkg:
  - state enum type.
  - Constants IMG_W, WIN, WPR, WIN_PER_ROW=65, WIN_TOTAL=4225, TPL_WORDS.
- One sub-module: win_tagger.
  - Contains the win_x/win_y/win_cnt counters and the count check.
  - Inputs: clear, step, check.
  - Output: cnt_err.

Test Plan:
- Reset during SEARCH (win_cnt=100) -> next cycle state IDLE, busy=0, win_cnt=0, mem_addr=FRAME_BASE.
- start, tpl_idx=5 while in TPL -> tpl_en pulse one cycle, mem_addr=1605; tpl_done -> wh_en=1 until wh_ack, then 0.
- SEARCH, wh_row=3, wh_col=7 -> mem_addr=67 same cycle; wh_row=79, wh_col=19 -> mem_addr=1599.
- 66 wh_ready pulses -> tags (0,0)..(64,0) then (0,1); win_cnt=66.
- Full pass: 4225 pulses, the last one coincident with wh_done -> done pulse, cnt_err=0, win_cnt=4225. Repeat with 4224 pulses -> cnt_err=1.
- start while busy, and wh_ready in IDLE -> no state change, win_cnt unchanged, win_valid=0.
